// File: rtl/vga_scanout_if.sv
`default_nettype none
// ============================================================================
// vga_scanout_if : VRAM video-port bundle (byte address out, read data back)
// Rev 1.0
// ============================================================================
interface vga_scanout_if;
    logic [15:0] vram_addr;
    logic [7:0]  vram_data;

    modport master (output vram_addr, input vram_data);
    modport slave  (input vram_addr, output vram_data);
endinterface
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// vga_scanout : VGA timing plus 1bpp framebuffer scanout, each pixel doubled 2x2.
// Optional define VGA_VBLANK_IRQ_EN adds vblank_irq / irq_ack.   Rev 1.0
// ============================================================================
module vga_scanout #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter logic [15:0] FB_BASE  = 16'h0000,
    parameter logic [2:0]  FG_RGB   = 3'b111,
    parameter logic [2:0]  BG_RGB   = 3'b000
) (
    input  logic          dot_clk,
    input  logic          reset,
    vga_scanout_if.master vram,
    output logic          r,
    output logic          g,
    output logic          b,
    output logic          hsync,
    output logic          vsync
`ifdef VGA_VBLANK_IRQ_EN
    ,
    output logic          vblank_irq,
    input  logic          irq_ack
`endif
);

    localparam int H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW            = $clog2(H_TOTAL);
    localparam int VW            = $clog2(V_TOTAL);
    localparam int WORDS_PER_ROW = H_ACTIVE / 16;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          active;
    logic          hsync_raw;
    logic          vsync_raw;
    logic [15:0]   row_offset;
    logic [15:0]   col_offset;

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (32'(h) == H_TOTAL - 1) begin
            h <= '0;
            if (32'(v) == V_TOTAL - 1) v <= '0;
            else                       v <= v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // Comparisons are done at 32 bits so sync edges equal to H_TOTAL/V_TOTAL cannot alias.
    always_comb begin
        active     = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
        hsync_raw  = !((32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC));
        vsync_raw  = !((32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC));
        row_offset = 16'(32'(v >> 1) * WORDS_PER_ROW);
        col_offset = 16'(h >> 4);
        vram.vram_addr = active ? (FB_BASE + row_offset + col_offset) : FB_BASE;
    end

    logic [3:0] s1_hlo;
    logic       s1_active;
    logic       s1_hsync;
    logic       s1_vsync;
    logic [7:0] fb_byte_q;
    logic [7:0] fb_byte;
    logic       pixel;

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            s1_hlo    <= 4'd0;
            s1_active <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
            fb_byte_q <= 8'd0;
        end else begin
            s1_hlo    <= h[3:0];
            s1_active <= active;
            s1_hsync  <= hsync_raw;
            s1_vsync  <= vsync_raw;
            fb_byte_q <= fb_byte;
        end
    end

    // The byte for a 16-dot group arrives while stage1 holds the group's first dot.
    always_comb begin
        fb_byte = (s1_hlo == 4'd0) ? vram.vram_data : fb_byte_q;
        pixel   = fb_byte[3'd7 - s1_hlo[3:1]];
    end

    always_ff @(posedge dot_clk) begin
        if (reset) begin
            {r, g, b} <= 3'b000;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            {r, g, b} <= s1_active ? (pixel ? FG_RGB : BG_RGB) : 3'b000;
            hsync     <= s1_hsync;
            vsync     <= s1_vsync;
        end
    end

`ifdef VGA_VBLANK_IRQ_EN
    always_ff @(posedge dot_clk) begin
        if (reset)                                    vblank_irq <= 1'b0;
        else if ((h == '0) && (32'(v) == V_ACTIVE))   vblank_irq <= 1'b1;
        else if (irq_ack)                             vblank_irq <= 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// tb_vga_scanout: randomized bench comparing a small-raster and a default-raster
// vga_scanout against a per-cycle reference model of the frame.
module tb_vga_scanout;

    localparam int S_HA = 64, S_HFP = 8, S_HS = 12, S_HBP = 12;
    localparam int S_VA = 12, S_VFP = 3, S_VS = 2,  S_VBP = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam logic [15:0] S_BASE = 16'hFFF8;
    localparam logic [2:0]  S_FG   = 3'b101;
    localparam logic [2:0]  S_BG   = 3'b010;
    localparam int D_HA = 640, D_HFP = 16, D_HS = 96, D_HT = 800, D_VA = 480;
    localparam int NC = 10000;

    logic dot_clk = 1'b0;
    logic reset;
    logic d_reset;
    logic r, g, b, hsync, vsync;
    logic dr, dg, db, dhsync, dvsync;
    vga_scanout_if s_bus();
    vga_scanout_if d_bus();
`ifdef VGA_VBLANK_IRQ_EN
    logic vblank_irq, irq_ack, d_irq;
    bit   ackh[NC];
`endif

    always #5 dot_clk = ~dot_clk;

    vga_scanout #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .FB_BASE(S_BASE), .FG_RGB(S_FG), .BG_RGB(S_BG)
    ) dut (
        .dot_clk(dot_clk), .reset(reset), .vram(s_bus),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
`ifdef VGA_VBLANK_IRQ_EN
        , .vblank_irq(vblank_irq), .irq_ack(irq_ack)
`endif
    );

    vga_scanout dut_def (
        .dot_clk(dot_clk), .reset(d_reset), .vram(d_bus),
        .r(dr), .g(dg), .b(db), .hsync(dhsync), .vsync(dvsync)
`ifdef VGA_VBLANK_IRQ_EN
        , .vblank_irq(d_irq), .irq_ack(1'b0)
`endif
    );

    int         mh[NC];
    int         mv[NC];
    int         dh[NC];
    int         dv[NC];
    logic [7:0] md[NC];
    bit         redge[NC];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    function automatic bit f_act(input int h, input int v, input int ha, input int va);
        return (h < ha) && (v < va);
    endfunction

    function automatic logic [15:0] f_addr(input int h, input int v, input int ha, input int va,
                                           input logic [15:0] base);
        if (f_act(h, v, ha, va)) return base + 16'((v / 2) * (ha / 16) + h / 16);
        return base;
    endfunction

    function automatic bit f_sync(input int x, input int start, input int width);
        return !((x >= start) && (x < start + width));
    endfunction

    function automatic bit in_reset_window(input int c);
        return redge[c] || (c >= 1 && redge[c-1]);
    endfunction

    // Pixel shown at cycle c: state from c-2, byte captured one cycle after its group start.
    function automatic logic [2:0] exp_rgb_s(input int c);
        int t, hh, grp;
        logic [7:0] by;
        if (in_reset_window(c)) return 3'b000;
        t  = c - 2;
        hh = mh[t];
        if (!f_act(hh, mv[t], S_HA, S_VA)) return 3'b000;
        grp = t - (hh % 16);
        by  = md[grp + 1];
        return by[7 - (hh % 16) / 2] ? S_FG : S_BG;
    endfunction

    initial begin
        int ch, cv, dhc, dvc;
        bit forced;
        logic [7:0] dat;
`ifdef VGA_VBLANK_IRQ_EN
        bit exp_irq;
        exp_irq = 1'b0;
        irq_ack = 1'b0;
`endif
        reset = 1'b1;
        d_reset = 1'b1;
        s_bus.vram_data = 8'h00;
        d_bus.vram_data = 8'hFF;
        repeat (2) @(posedge dot_clk);
        ch = 0; cv = 0; dhc = 0; dvc = 0; forced = 1'b0;
        redge[0] = 1'b1;

        for (int c = 0; c < NC; c++) begin
            @(negedge dot_clk);
            mh[c] = ch; mv[c] = cv; dh[c] = dhc; dv[c] = dvc;

            check("s_addr", 32'(s_bus.vram_addr), 32'(f_addr(ch, cv, S_HA, S_VA, S_BASE)));
            check("s_rgb", 32'({r, g, b}), 32'(exp_rgb_s(c)));
            if (in_reset_window(c)) begin
                check("s_hsync_rst", 32'(hsync), 32'd1);
                check("s_vsync_rst", 32'(vsync), 32'd1);
            end else begin
                check("s_hsync", 32'(hsync), 32'(f_sync(mh[c-2], S_HA + S_HFP, S_HS)));
                check("s_vsync", 32'(vsync), 32'(f_sync(mv[c-2], S_VA + S_VFP, S_VS)));
            end
`ifdef VGA_VBLANK_IRQ_EN
            if (redge[c])                             exp_irq = 1'b0;
            else if (mh[c-1] == 0 && mv[c-1] == S_VA) exp_irq = 1'b1;
            else if (ackh[c-1])                       exp_irq = 1'b0;
            check("s_irq", 32'(vblank_irq), 32'(exp_irq));
`endif

            check("d_addr", 32'(d_bus.vram_addr), 32'(f_addr(dhc, dvc, D_HA, D_VA, 16'h0000)));
            if (dhc == 0 && dvc == 0)   check("d_addr_h0v0", 32'(d_bus.vram_addr), 32'h0000);
            if (dhc == 16 && dvc == 2)  check("d_addr_h16v2", 32'(d_bus.vram_addr), 32'h0029);
            if (dhc == 640)             check("d_addr_h640", 32'(d_bus.vram_addr), 32'h0000);
            if (c < 2) begin
                check("d_rgb_rst", 32'({dr, dg, db}), 32'd0);
                check("d_hsync_rst", 32'(dhsync), 32'd1);
            end else begin
                check("d_rgb", 32'({dr, dg, db}),
                      f_act(dh[c-2], dv[c-2], D_HA, D_VA) ? 32'd7 : 32'd0);
                check("d_hsync", 32'(dhsync), 32'(f_sync(dh[c-2], D_HA + D_HFP, D_HS)));
                check("d_vsync", 32'(dvsync), 32'd1);
            end

            if (c < 3000)      dat = 8'h80;
            else if (c < 6000) dat = 8'hFF;
            else               dat = 8'($urandom);
            s_bus.vram_data = dat;
            md[c] = dat;
            reset = (c >= 6000) && ($urandom_range(0, 1499) == 0);
            if (c > 7000 && !forced && ch == 40 && cv == 5) begin
                reset  = 1'b1;
                forced = 1'b1;
            end
            d_reset = 1'b0;
`ifdef VGA_VBLANK_IRQ_EN
            irq_ack = ($urandom_range(0, 39) == 0) || (ch == 0 && cv == S_VA);
            ackh[c] = irq_ack;
`endif
            if (c + 1 < NC) redge[c+1] = reset;

            if (reset) begin
                ch = 0; cv = 0;
            end else if (ch == S_HT - 1) begin
                ch = 0;
                cv = (cv == S_VT - 1) ? 0 : cv + 1;
            end else begin
                ch = ch + 1;
            end
            dhc = (dhc == D_HT - 1) ? 0 : dhc + 1;
            if (dhc == 0) dvc = dvc + 1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
